// File: rtl/nios_sd_loader_cpu_resp.sv
// Response-byte FIFO on the Nios data bus.
// The CPU writes bytes into the FIFO through a small Avalon-MM slave.
// The host-side consumer drains them through a valid/ready handshake.
module nios_sd_loader_cpu_resp #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          irq_en_q, irq_en_d;
    logic [7:0]    last_wr_q, last_wr_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          irq_q;

    logic wr_en, full, empty, push, push_ok, pop, flush;

    assign wr_en   = chipselect & ~write_n;
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push    = wr_en & (address == 2'd0);
    // Fullness is judged on the current level, so a push into a full FIFO
    // is dropped even when a pop happens in the same cycle.
    assign push_ok = push & ~full;
    assign pop     = ~empty & out_ready;
    assign flush   = wr_en & (address == 2'd2) & writedata[1];

    // Next-state computation for pointers, level, flags and read mux.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        irq_en_d   = irq_en_q;
        last_wr_d  = last_wr_q;
        readdata_d = '0;

        if (push) begin
            last_wr_d = writedata[7:0];
        end
        if (push & full) begin
            ovf_d = 1'b1;
        end
        if (wr_en && (address == 2'd2)) begin
            irq_en_d = writedata[0];
            if (writedata[2]) begin
                ovf_d = 1'b0;
            end
        end

        // Flush wins over any concurrent push or pop.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        case (address)
            2'd0: readdata_d[7:0] = last_wr_q;
            2'd1: begin
                readdata_d[0]       = full;
                readdata_d[1]       = empty;
                readdata_d[2]       = ovf_q;
                readdata_d[8 +: LW] = level_q;
            end
            2'd2: readdata_d[0] = irq_en_q;
            default: readdata_d = '0;
        endcase
    end

    // Control state and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            last_wr_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            last_wr_q  <= last_wr_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_en_q & (empty | ovf_q);
        end
    end

    // Byte storage; only slots below the level are ever presented.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= writedata[7:0];
        end
    end

    // Head byte is masked while empty so stale or unwritten slots never leak out.
    always_comb begin
        out_valid = ~empty;
        out_port  = empty ? 8'h00 : mem_q[rd_ptr_q];
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_sd_loader_cpu_resp.sv
// Directed testbench for the response-byte FIFO slave.
module tb_nios_sd_loader_cpu_resp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        out_valid;
    logic        out_ready;
    logic        irq;

    int n_checks = 0;
    int n_fails  = 0;

    nios_sd_loader_cpu_resp #(.DEPTH(4), .LW(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n    = 1'b0;
        address    = 2'd1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        out_ready  = 1'b0;
        tick();
        n_checks++;
        if (readdata !== 32'h0 || out_valid !== 1'b0 || out_port !== 8'h00 || irq !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_hold: rd=%h valid=%b port=%h irq=%b, want 0", readdata, out_valid, out_port, irq);
        end
        reset_n = 1'b1;
        cpu_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0000_0002) begin
            n_fails++;
            $display("FAIL reset_status: got %h want 00000002", rd);
        end
        n_checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_outs: valid=%b irq=%b want 0 0", out_valid, irq);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        do_reset();
        cpu_write(2'd0, 32'h0000_00A5);
        n_checks++;
        if (out_valid !== 1'b1 || out_port !== 8'hA5) begin
            n_fails++;
            $display("FAIL first_push: valid=%b port=%h want 1 a5", out_valid, out_port);
        end
        cpu_write(2'd0, 32'hFFFF_FF3C);
        cpu_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0000_0200) begin
            n_fails++;
            $display("FAIL basic_status: got %h want 00000200", rd);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_port !== 8'hA5) begin
            n_fails++;
            $display("FAIL basic_head: valid=%b port=%h want 1 a5", out_valid, out_port);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_port !== 8'h3C) begin
            n_fails++;
            $display("FAIL basic_pop1: valid=%b port=%h want 1 3c", out_valid, out_port);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL basic_pop2: valid=%b want 0", out_valid);
        end
        tick();
        out_ready = 1'b0;
        cpu_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0000_0002) begin
            n_fails++;
            $display("FAIL basic_underflow: status %h want 00000002", rd);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [7:0]  exp_drain [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        for (int i = 1; i <= 5; i++) cpu_write(2'd0, 32'(i));
        cpu_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0000_0405) begin
            n_fails++;
            $display("FAIL ovf_status: got %h want 00000405", rd);
        end
        cpu_read(2'd0, rd);
        n_checks++;
        if (rd !== 32'h0000_0005) begin
            n_fails++;
            $display("FAIL ovf_last_wr: got %h want 00000005", rd);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_port !== exp_drain[i]) begin
                n_fails++;
                $display("FAIL ovf_drain[%0d]: valid=%b port=%h want 1 %h", i, out_valid, out_port, exp_drain[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL ovf_drained: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] rd;
        logic [7:0]  exp_drain [3] = '{8'h11, 8'h12, 8'h13};
        do_reset();
        for (int i = 0; i < 4; i++) cpu_write(2'd0, 32'h10 + 32'(i));
        // Push while full with a pop in the same cycle: pop happens, push dropped.
        out_ready = 1'b1;
        cpu_write(2'd0, 32'h77);
        out_ready = 1'b0;
        cpu_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0000_0304) begin
            n_fails++;
            $display("FAIL fullpp_status: got %h want 00000304", rd);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_port !== exp_drain[i]) begin
                n_fails++;
                $display("FAIL fullpp_drain[%0d]: valid=%b port=%h want 1 %h", i, out_valid, out_port, exp_drain[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL fullpp_no77: valid=%b port=%h want empty", out_valid, out_port);
        end
        cpu_write(2'd2, 32'h4);
        cpu_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0000_0002) begin
            n_fails++;
            $display("FAIL ovf_clear: got %h want 00000002", rd);
        end
    endtask

    task automatic test_flush_irq();
        logic [31:0] rd;
        do_reset();
        for (int i = 0; i < 3; i++) cpu_write(2'd0, 32'h20 + 32'(i));
        out_ready = 1'b1;
        cpu_write(2'd2, 32'h3);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || irq !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_empty: valid=%b irq=%b want 0 0", out_valid, irq);
        end
        cpu_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0000_0002) begin
            n_fails++;
            $display("FAIL flush_status: got %h want 00000002", rd);
        end
        n_checks++;
        if (irq !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_irq: irq=%b want 1", irq);
        end
        cpu_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h0000_0001) begin
            n_fails++;
            $display("FAIL ctrl_read: got %h want 00000001", rd);
        end
        cpu_write(2'd3, 32'hFFFF_FFFF);
        cpu_read(2'd3, rd);
        n_checks++;
        if (rd !== 32'h0 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL addr3: rd=%h valid=%b want 0 0", rd, out_valid);
        end
        // A non-empty FIFO with irq_en set and no overflow drops irq.
        cpu_write(2'd0, 32'h55);
        tick();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fails++;
            $display("FAIL irq_nonempty: irq=%b want 0", irq);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] rd;
        do_reset();
        cpu_write(2'd0, 32'h61);
        cpu_write(2'd0, 32'h62);
        cpu_write(2'd2, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_port !== 8'h00) begin
            n_fails++;
            $display("FAIL async_reset: valid=%b port=%h want 0 00", out_valid, out_port);
        end
        tick();
        reset_n = 1'b1;
        cpu_read(2'd1, rd);
        n_checks++;
        if (rd !== 32'h0000_0002 || irq !== 1'b0 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL post_reset: status=%h irq=%b valid=%b want 00000002 0 0", rd, irq, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_flush_irq();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
